// File: rtl/my_clipper_decode.sv
// my_clipper_decode: Avalon-ST video input parser.
// Control packets (type 0xF) latch width/height/interlaced onto sideband outputs,
// video packets (type 0x0) are forwarded with the header beat stripped, and all
// other packet types are consumed and dropped.
// Optional: define MY_CLIPPER_DECODE_FRAME_CNT_EN to add the frame_count output.
module my_clipper_decode #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_BITS   = 8,
    parameter int DATA_PLANES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    output logic [15:0]           video_width,
    output logic [15:0]           video_height,
    output logic [3:0]            video_interlaced,
    output logic                  ctrl_update,
    output logic                  packet_error
`ifdef MY_CLIPPER_DECODE_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_count
`endif
);

    typedef enum logic [1:0] {IDLE, CTRL, VIDEO, DROP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  nib_cnt, nib_cnt_nxt;
    logic [4:0]  nib_sum;
    logic [35:0] shadow, shadow_nxt;
    logic        first_pix;
    logic        accept, header, ctrl_beat, ctrl_done, commit, error_nxt;

    // Handshake, pass-through datapath and beat classification
    always_comb begin
        din_ready          = (state == VIDEO) ? dout_ready : 1'b1;
        accept             = din_valid && din_ready;
        header             = accept && din_startofpacket;
        ctrl_beat          = accept && !din_startofpacket && (state == CTRL);
        ctrl_done          = ctrl_beat && din_endofpacket;
        dout_data          = din_data;
        dout_valid         = (state == VIDEO) && din_valid && !din_startofpacket;
        dout_startofpacket = dout_valid && first_pix;
        dout_endofpacket   = dout_valid && din_endofpacket;
    end

    // Control nibble assembly: plane p of this beat lands in slot nib_cnt+p
    always_comb begin
        shadow_nxt  = shadow;
        nib_cnt_nxt = nib_cnt;
        nib_sum     = {1'b0, nib_cnt} + 5'(DATA_PLANES);
        if (header) begin
            shadow_nxt  = '0;
            nib_cnt_nxt = '0;
        end else if (ctrl_beat) begin
            for (int unsigned n = 0; n < 9; n++) begin
                for (int unsigned p = 0; p < DATA_PLANES; p++) begin
                    if (32'(nib_cnt) + p == n)
                        shadow_nxt[35-4*n -: 4] = din_data[p*DATA_BITS +: 4];
                end
            end
            nib_cnt_nxt = (nib_sum >= 5'd9) ? 4'd9 : nib_sum[3:0];
        end
        commit    = ctrl_done && (nib_sum >= 5'd9);
        error_nxt = (header && (state != IDLE)) || (ctrl_done && (nib_sum < 5'd9));
    end

    // Next-state decode; a header beat restarts parsing from any state
    always_comb begin
        state_nxt = state;
        if (header) begin
            if (din_endofpacket)
                state_nxt = IDLE;
            else if (din_data[3:0] == 4'h0)
                state_nxt = VIDEO;
            else if (din_data[3:0] == 4'hF)
                state_nxt = CTRL;
            else
                state_nxt = DROP;
        end else if (accept && din_endofpacket && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // State, shadow, committed outputs and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            nib_cnt          <= '0;
            shadow           <= '0;
            first_pix        <= 1'b0;
            video_width      <= '0;
            video_height     <= '0;
            video_interlaced <= '0;
            ctrl_update      <= 1'b0;
            packet_error     <= 1'b0;
        end else begin
            state        <= state_nxt;
            nib_cnt      <= nib_cnt_nxt;
            shadow       <= shadow_nxt;
            ctrl_update  <= commit;
            packet_error <= error_nxt;
            if (header)
                first_pix <= 1'b1;
            else if (dout_valid && dout_ready)
                first_pix <= 1'b0;
            if (commit) begin
                video_width      <= shadow_nxt[35:20];
                video_height     <= shadow_nxt[19:4];
                video_interlaced <= shadow_nxt[3:0];
            end
        end
    end

`ifdef MY_CLIPPER_DECODE_FRAME_CNT_EN
    // Count completed forwarded frames
    always_ff @(posedge clk) begin
        if (!rst_n)
            frame_count <= '0;
        else if (dout_valid && dout_ready && din_endofpacket)
            frame_count <= frame_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_my_clipper_decode.sv
// Directed testbench for my_clipper_decode (1-plane and 3-plane instances).
module tb_my_clipper_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din_data;
    logic        din_valid, din_ready, din_sop, din_eop;
    logic [7:0]  dout_data;
    logic        dout_valid, dout_ready, dout_sop, dout_eop;
    logic [15:0] vw, vh;
    logic [3:0]  vi;
    logic        cu, perr;
`ifdef MY_CLIPPER_DECODE_FRAME_CNT_EN
    logic [15:0] fcnt, fcnt3;
`endif

    logic [23:0] d3_data;
    logic        d3_valid, d3_ready, d3_sop, d3_eop;
    logic [23:0] q3_data;
    logic        q3_valid, q3_ready, q3_sop, q3_eop;
    logic [15:0] vw3, vh3;
    logic [3:0]  vi3;
    logic        cu3, perr3;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_w = '0, exp_h = '0;
    logic [3:0]  exp_i = '0;

    always #5 clk = ~clk;

    my_clipper_decode #(.DATA_WIDTH(8), .DATA_BITS(8), .DATA_PLANES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
        .din_startofpacket(din_sop), .din_endofpacket(din_eop),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_startofpacket(dout_sop), .dout_endofpacket(dout_eop),
        .video_width(vw), .video_height(vh), .video_interlaced(vi),
        .ctrl_update(cu), .packet_error(perr)
`ifdef MY_CLIPPER_DECODE_FRAME_CNT_EN
        , .frame_count(fcnt)
`endif
    );

    my_clipper_decode #(.DATA_WIDTH(24), .DATA_BITS(8), .DATA_PLANES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .din_data(d3_data), .din_valid(d3_valid), .din_ready(d3_ready),
        .din_startofpacket(d3_sop), .din_endofpacket(d3_eop),
        .dout_data(q3_data), .dout_valid(q3_valid), .dout_ready(q3_ready),
        .dout_startofpacket(q3_sop), .dout_endofpacket(q3_eop),
        .video_width(vw3), .video_height(vh3), .video_interlaced(vi3),
        .ctrl_update(cu3), .packet_error(perr3)
`ifdef MY_CLIPPER_DECODE_FRAME_CNT_EN
        , .frame_count(fcnt3)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic s, input logic e);
        din_data  = d;
        din_sop   = s;
        din_eop   = e;
        din_valid = 1'b1;
    endtask

    task automatic idle;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
        din_data  = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        tests++; if (vw !== 16'h0) begin fails++; $display("FAIL reset_width got %h expected 0000", vw); end
        tests++; if (vh !== 16'h0) begin fails++; $display("FAIL reset_height got %h expected 0000", vh); end
        tests++; if (vi !== 4'h0) begin fails++; $display("FAIL reset_interlaced got %h expected 0", vi); end
        tests++; if (cu !== 1'b0 || perr !== 1'b0) begin fails++; $display("FAIL reset_pulses got cu=%b perr=%b expected 0 0", cu, perr); end
        tests++; if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin fails++; $display("FAIL reset_handshake got ready=%b valid=%b expected 1 0", din_ready, dout_valid); end
`ifdef MY_CLIPPER_DECODE_FRAME_CNT_EN
        tests++; if (fcnt !== 16'h0) begin fails++; $display("FAIL reset_frame_count got %h expected 0000", fcnt); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_ctrl(input logic [3:0] n0, n1, n2, n3, n4, n5, n6, n7, n8);
        logic [3:0] nib [0:8];
        nib = '{n0, n1, n2, n3, n4, n5, n6, n7, n8};
        drive(8'h0F, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive({4'h0, nib[i]}, 1'b0, i == 8);
            tick();
        end
        idle();
    endtask

    task automatic test_ctrl_p1;
        // 640x480 progressive-ish, interlace nibble 3
        send_ctrl(4'h0, 4'h2, 4'h8, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 4'h3);
        exp_w = 16'h0280; exp_h = 16'h01E0; exp_i = 4'h3;
        tests++; if (vw !== exp_w) begin fails++; $display("FAIL ctrl1_width got %h expected %h", vw, exp_w); end
        tests++; if (vh !== exp_h) begin fails++; $display("FAIL ctrl1_height got %h expected %h", vh, exp_h); end
        tests++; if (vi !== exp_i) begin fails++; $display("FAIL ctrl1_interlaced got %h expected %h", vi, exp_i); end
        tests++; if (cu !== 1'b1) begin fails++; $display("FAIL ctrl1_update got %b expected 1", cu); end
        tests++; if (perr !== 1'b0) begin fails++; $display("FAIL ctrl1_error got %b expected 0", perr); end
        tick();
        tests++; if (cu !== 1'b0) begin fails++; $display("FAIL ctrl1_update_width got %b expected 0", cu); end
        // 1920x1080, interlace nibble A
        send_ctrl(4'h0, 4'h7, 4'h8, 4'h0, 4'h0, 4'h4, 4'h3, 4'h8, 4'hA);
        exp_w = 16'h0780; exp_h = 16'h0438; exp_i = 4'hA;
        tests++; if ({vw, vh, vi} !== {exp_w, exp_h, exp_i}) begin fails++; $display("FAIL ctrl2_values got %h/%h/%h expected %h/%h/%h", vw, vh, vi, exp_w, exp_h, exp_i); end
        tests++; if (cu !== 1'b1) begin fails++; $display("FAIL ctrl2_update got %b expected 1", cu); end
        tick();
    endtask

    task automatic test_video;
        logic [7:0] px [0:3];
        int i, cyc;
        logic rdy;
        px = '{8'h11, 8'h22, 8'h33, 8'h44};
        dout_ready = 1'b1;
        drive(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL video_header_valid got %b expected 0", dout_valid); end
        tick();
        i = 0; cyc = 0; rdy = 1'b1;
        while (i < 4 && cyc < 20) begin
            drive(px[i], 1'b0, i == 3);
            dout_ready = rdy;
            @(negedge clk);
            tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL video_valid[%0d] got %b expected 1", i, dout_valid); end
            tests++; if (dout_data !== px[i]) begin fails++; $display("FAIL video_data[%0d] got %h expected %h", i, dout_data, px[i]); end
            tests++; if (dout_sop !== (i == 0)) begin fails++; $display("FAIL video_sop[%0d] got %b expected %b", i, dout_sop, i == 0); end
            tests++; if (dout_eop !== (i == 3)) begin fails++; $display("FAIL video_eop[%0d] got %b expected %b", i, dout_eop, i == 3); end
            tests++; if (din_ready !== rdy) begin fails++; $display("FAIL video_ready[%0d] got %b expected %b", i, din_ready, rdy); end
            @(posedge clk);
            if (rdy) i++;
            #1;
            rdy = !rdy;
            cyc++;
        end
        tests++; if (i != 4) begin fails++; $display("FAIL video_timeout got %0d pixels expected 4", i); end
        idle();
        dout_ready = 1'b0;
        #1;
        tests++; if (din_ready !== 1'b1) begin fails++; $display("FAIL video_back_idle got ready=%b expected 1", din_ready); end
`ifdef MY_CLIPPER_DECODE_FRAME_CNT_EN
        tests++; if (fcnt !== 16'd1) begin fails++; $display("FAIL video_frame_count got %0d expected 1", fcnt); end
`endif
        tick();
    endtask

    task automatic test_drop;
        dout_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive((k == 0) ? 8'h05 : 8'(k), k == 0, k == 5);
            @(negedge clk);
            tests++; if (din_ready !== 1'b1) begin fails++; $display("FAIL drop_ready[%0d] got %b expected 1", k, din_ready); end
            tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL drop_valid[%0d] got %b expected 0", k, dout_valid); end
            tick();
        end
        idle();
        tests++; if ({vw, vh, vi} !== {exp_w, exp_h, exp_i}) begin fails++; $display("FAIL drop_ctrl_kept got %h/%h/%h expected %h/%h/%h", vw, vh, vi, exp_w, exp_h, exp_i); end
        tests++; if (cu !== 1'b0 || perr !== 1'b0) begin fails++; $display("FAIL drop_pulses got cu=%b perr=%b expected 0 0", cu, perr); end
        tick();
    endtask

    task automatic test_trunc;
        drive(8'h0F, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(8'(k), 1'b0, k == 4);
            tick();
        end
        idle();
        tests++; if (perr !== 1'b1) begin fails++; $display("FAIL trunc_error got %b expected 1", perr); end
        tests++; if (cu !== 1'b0) begin fails++; $display("FAIL trunc_update got %b expected 0", cu); end
        tests++; if ({vw, vh, vi} !== {exp_w, exp_h, exp_i}) begin fails++; $display("FAIL trunc_ctrl_kept got %h/%h/%h expected %h/%h/%h", vw, vh, vi, exp_w, exp_h, exp_i); end
        tick();
        tests++; if (perr !== 1'b0) begin fails++; $display("FAIL trunc_error_width got %b expected 0", perr); end
    endtask

    task automatic test_sop_mid_video;
        dout_ready = 1'b1;
        drive(8'h00, 1'b1, 1'b0); tick();
        drive(8'hAA, 1'b0, 1'b0); tick();
        drive(8'hBB, 1'b0, 1'b0); tick();
        // New header while downstream stalls: must be held off
        dout_ready = 1'b0;
        drive(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        tests++; if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin fails++; $display("FAIL mid_sop_stall got ready=%b valid=%b expected 0 0", din_ready, dout_valid); end
        tick();
        tests++; if (perr !== 1'b0) begin fails++; $display("FAIL mid_sop_no_accept_err got %b expected 0", perr); end
        dout_ready = 1'b1;
        tick();
        tests++; if (perr !== 1'b1) begin fails++; $display("FAIL mid_sop_error got %b expected 1", perr); end
`ifdef MY_CLIPPER_DECODE_FRAME_CNT_EN
        tests++; if (fcnt !== 16'd1) begin fails++; $display("FAIL mid_sop_aborted_count got %0d expected 1", fcnt); end
`endif
        drive(8'hCC, 1'b0, 1'b0);
        @(negedge clk);
        tests++; if (dout_valid !== 1'b1 || dout_sop !== 1'b1 || dout_data !== 8'hCC) begin fails++; $display("FAIL mid_sop_restart got v=%b sop=%b d=%h expected 1 1 cc", dout_valid, dout_sop, dout_data); end
        tick();
        tests++; if (perr !== 1'b0) begin fails++; $display("FAIL mid_sop_error_width got %b expected 0", perr); end
        drive(8'hDD, 1'b0, 1'b1);
        @(negedge clk);
        tests++; if (dout_sop !== 1'b0 || dout_eop !== 1'b1) begin fails++; $display("FAIL mid_sop_last got sop=%b eop=%b expected 0 1", dout_sop, dout_eop); end
        tick();
        idle();
`ifdef MY_CLIPPER_DECODE_FRAME_CNT_EN
        tests++; if (fcnt !== 16'd2) begin fails++; $display("FAIL mid_sop_frame_count got %0d expected 2", fcnt); end
`endif
        tick();
    endtask

    task automatic test_planes3;
        logic [23:0] beats [0:3];
        beats = '{24'h00000F, 24'h080200, 24'h010000, 24'h03000E};
        for (int k = 0; k < 4; k++) begin
            d3_data  = beats[k];
            d3_sop   = (k == 0);
            d3_eop   = (k == 3);
            d3_valid = 1'b1;
            tick();
        end
        d3_valid = 1'b0; d3_sop = 1'b0; d3_eop = 1'b0;
        tests++; if (vw3 !== 16'h0280) begin fails++; $display("FAIL p3_width got %h expected 0280", vw3); end
        tests++; if (vh3 !== 16'h01E0) begin fails++; $display("FAIL p3_height got %h expected 01e0", vh3); end
        tests++; if (vi3 !== 4'h3) begin fails++; $display("FAIL p3_interlaced got %h expected 3", vi3); end
        tests++; if (cu3 !== 1'b1 || perr3 !== 1'b0) begin fails++; $display("FAIL p3_pulses got cu=%b perr=%b expected 1 0", cu3, perr3); end
        tick();
    endtask

    task automatic test_reset_midpacket;
        drive(8'h0F, 1'b1, 1'b0); tick();
        drive(8'h01, 1'b0, 1'b0); tick();
        drive(8'h02, 1'b0, 1'b0); tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++; if ({vw, vh, vi} !== 36'h0) begin fails++; $display("FAIL rst_mid_values got %h/%h/%h expected 0/0/0", vw, vh, vi); end
`ifdef MY_CLIPPER_DECODE_FRAME_CNT_EN
        tests++; if (fcnt !== 16'd0) begin fails++; $display("FAIL rst_mid_frame_count got %0d expected 0", fcnt); end
`endif
        // Leftover tail of the old packet arrives in IDLE: silently discarded
        drive(8'h05, 1'b0, 1'b1); tick();
        idle();
        tests++; if (cu !== 1'b0 || perr !== 1'b0) begin fails++; $display("FAIL rst_mid_tail got cu=%b perr=%b expected 0 0", cu, perr); end
        tests++; if (vw !== 16'h0) begin fails++; $display("FAIL rst_mid_width_held got %h expected 0000", vw); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        dout_ready = 1'b1;
        d3_data = '0; d3_valid = 1'b0; d3_sop = 1'b0; d3_eop = 1'b0;
        q3_ready = 1'b1;
        test_reset();
        test_ctrl_p1();
        test_video();
        test_drop();
        test_trunc();
        test_sop_mid_video();
        test_planes3();
        test_reset_midpacket();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
